tt_um_minhho05_alu_driver: RTL and testbench

Initiator-side companion to the team's registered 4-bit ALU tile. The block buffers a short list of ALU commands, loaded over the Tiny Tapeout pins, then issues them one at a time to an external ALU. For each command it drives operands and opcode, waits a fixed latency, captures the 8-bit result and accumulates a checksum. Board-level wiring: our `uo_out` goes to ALU `ui_in`, our `uio_out[2:0]` goes to ALU `uio_in[2:0]`, and ALU `uo_out` comes back on our `ui_in`.

---
 rtl/tt_um_minhho05_alu_driver_if.sv | 20 ++
 rtl/tt_um_minhho05_alu_driver.sv | 159 +++++++++++++++
 tb/tb_tt_um_minhho05_alu_driver.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_um_minhho05_alu_driver_if.sv
// Tiny Tapeout pin bundle for the ALU driver tile.
// master is the tile side; slave is the board/bench side.
interface tt_um_minhho05_alu_driver_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );

  modport slave (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_minhho05_alu_driver.sv
// Buffers ALU commands loaded over the TT pins, issues them to an external registered ALU
// one at a time, and accumulates an 8-bit checksum of the returned results.
module tt_um_minhho05_alu_driver #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 2
) (
  input logic                               clk,
  input logic                               rst_n,
  tt_um_minhho05_alu_driver_if.master       bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          wr_s_q, wr_d_q, start_s_q, start_d_q;
  logic          wr_evt, start_evt;
  logic          load_en, latch_en, push, pop;
  logic [7:0]    latch_q;
  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    drv_q, drv_d;
  logic [2:0]    op_q, op_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          unused_pins;

  assign unused_pins = &{1'b0, bus.ena, bus.uio_in[7:6], bus.uio_in[2:0]};

  // Rising-edge detect on the already-registered strobes.
  assign wr_evt    = wr_s_q & ~wr_d_q;
  assign start_evt = start_s_q & ~start_d_q;

  assign load_en  = wr_evt & ((state_q == StIdle) | (state_q == StDone));
  assign latch_en = load_en & ~bus.uio_in[5];
  assign push     = load_en & bus.uio_in[5] & (count_q != (AW+1)'(DEPTH));
  assign pop      = (state_q == StWait) & (cnt_q == '0);

  always_comb begin
    count_d = count_q;
    if (push) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    unique case (state_q)
      StIdle: begin
        if (start_evt) begin
          if (count_q != '0) begin
            sum_d   = 8'h00;
            state_d = StIssue;
          end else begin
            state_d = StDone;
          end
        end
      end
      StIssue: begin
        cnt_d   = CW'(LATENCY - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          sum_d   = sum_q + bus.ui_in;
          // count_q still includes the entry being popped this cycle
          state_d = (count_q > (AW+1)'(1)) ? StIssue : StDone;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StDone: begin
        if (start_evt | wr_evt) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    drv_d = drv_q;
    op_d  = op_q;
    if (state_q == StIssue) begin
      {drv_d, op_d} = mem_q[rd_ptr_q];
    end
    if (state_d == StIdle) begin
      drv_d = 8'h00;
      op_d  = 3'b000;
    end else if (state_d == StDone) begin
      drv_d = sum_d;
      op_d  = 3'b000;
    end
    busy_d = (state_d == StIssue) | (state_d == StWait);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wr_s_q    <= 1'b0;
      wr_d_q    <= 1'b0;
      start_s_q <= 1'b0;
      start_d_q <= 1'b0;
      latch_q   <= 8'h00;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      sum_q     <= 8'h00;
      cnt_q     <= '0;
      drv_q     <= 8'h00;
      op_q      <= 3'b000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_s_q    <= bus.uio_in[3];
      wr_d_q    <= wr_s_q;
      start_s_q <= bus.uio_in[4];
      start_d_q <= start_s_q;
      count_q   <= count_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      drv_q     <= drv_d;
      op_q      <= op_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      if (latch_en) begin
        latch_q <= bus.ui_in;
      end
      if (push) begin
        mem_q[wr_ptr_q] <= {latch_q, bus.ui_in[2:0]};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  assign bus.uo_out  = drv_q;
  assign bus.uio_out = {done_q, busy_q, 3'b000, op_q};
  assign bus.uio_oe  = 8'b1100_0111;

endmodule

// File: tb/tb_tt_um_minhho05_alu_driver.sv
// Bench for the ALU driver: external registered ALU model, queue-based reference of command
// lists and checksums, and an independent monitor that checks drives and DONE results.
module tb_tt_um_minhho05_alu_driver;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 2;
  localparam int unsigned PER   = LAT + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic [7:0] alu_q = 8'h00;

  int total = 0;
  int bad = 0;

  logic [10:0] exp_cmd[$];
  logic [7:0]  exp_sum[$];
  int          exp_cyc[$];
  logic [10:0] mdl_fifo[$];
  logic [7:0]  mdl_sum = 8'h00;
  bit          in_done = 1'b0;

  always #5 clk = ~clk;

  tt_um_minhho05_alu_driver_if bus ();

  tt_um_minhho05_alu_driver #(
    .DEPTH  (DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.ena    = 1'b1;
  assign bus.uio_in = {2'b00, sel, start, wr, 3'b000};
  assign bus.ui_in  = bus.uio_out[6] ? alu_q : ld_data;

  // The team ALU: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or; others hold.
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op, input logic [7:0] held);
    case (op)
      3'b000:  return 8'(a) + 8'(b);
      3'b001:  return 8'(a) - 8'(b);
      3'b010:  return 8'(a) * 8'(b);
      3'b011:  return (b == 4'd0) ? 8'hFF : 8'(a) / 8'(b);
      3'b100:  return {4'h0, a & b};
      3'b101:  return {4'h0, a | b};
      default: return held;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_q <= alu_fn(bus.uo_out[7:4], bus.uo_out[3:0], bus.uio_out[2:0], alu_q);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: event with no expectation or timed out", name);
  endtask

  // Monitor: command drive on the first WAIT cycle of each slot, checksum on done rise.
  int   busy_cnt = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    logic [10:0] e;
    if (!rst_n) begin
      busy_cnt  = 0;
      done_prev = 1'b0;
    end else begin
      if (bus.uio_out[6]) begin
        if (busy_cnt % PER == 1) begin
          if (exp_cmd.size() == 0) begin
            miss("cmd_drive");
          end else begin
            e = exp_cmd.pop_front();
            check("cmd_drive", {21'd0, bus.uo_out, bus.uio_out[2:0]}, {21'd0, e});
          end
        end
        busy_cnt++;
      end
      if (bus.uio_out[7] && !done_prev) begin
        if (exp_sum.size() == 0) begin
          miss("done_sum");
        end else begin
          check("done_sum", {24'd0, bus.uo_out}, {24'd0, exp_sum.pop_front()});
          check("done_op", {29'd0, bus.uio_out[2:0]}, 32'd0);
          check("busy_cycles", busy_cnt, exp_cyc.pop_front());
        end
        busy_cnt = 0;
      end
      done_prev = bus.uio_out[7];
    end
  end

  task automatic strobe(input bit is_start, input logic s, input logic [7:0] d);
    @(negedge clk);
    sel     = s;
    ld_data = d;
    if (is_start) start = 1'b1;
    else          wr = 1'b1;
    repeat (2) @(negedge clk);
    wr    = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    in_done = 1'b0;
    strobe(1'b0, 1'b0, {a, b});
    strobe(1'b0, 1'b1, {5'($urandom), op});
    if (mdl_fifo.size() < DEPTH) mdl_fifo.push_back({a, b, op});
  endtask

  task automatic leave_done();
    if (in_done) begin
      strobe(1'b1, sel, ld_data);
      check("done_clear", {31'd0, bus.uio_out[7]}, 32'd0);
      check("idle_uo", {24'd0, bus.uo_out}, 32'd0);
      in_done = 1'b0;
    end
  endtask

  // Reference: results in order, undecoded ops repeat the previous result (0 at run start).
  task automatic run_expect();
    logic [7:0]  prev, r, s;
    logic [10:0] c;
    leave_done();
    if (mdl_fifo.size() > 0) begin
      prev = 8'h00;
      s    = 8'h00;
      foreach (mdl_fifo[i]) begin
        c    = mdl_fifo[i];
        r    = alu_fn(c[10:7], c[6:3], c[2:0], prev);
        prev = r;
        s    = s + r;
        exp_cmd.push_back(c);
      end
      mdl_sum = s;
      exp_cyc.push_back(mdl_fifo.size() * PER);
      mdl_fifo.delete();
    end else begin
      exp_cyc.push_back(0);
    end
    exp_sum.push_back(mdl_sum);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.uio_out[7] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.uio_out[7]) miss("done_timeout");
    @(negedge clk);
    in_done = 1'b1;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!bus.uio_out[6] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.uio_out[6]) miss("busy_timeout");
  endtask

  task automatic run();
    run_expect();
    strobe(1'b1, sel, ld_data);
    wait_done();
  endtask

  task automatic load_four();
    push_cmd(4'd15, 4'd15, 3'b010);
    push_cmd(4'd9, 4'd4, 3'b001);
    push_cmd(4'd12, 4'd10, 3'b100);
    push_cmd(4'd6, 4'd3, 3'b011);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_uo", {24'd0, bus.uo_out}, 32'd0);
    check("rst_uio", {24'd0, bus.uio_out}, 32'd0);
    check("uio_oe", {24'd0, bus.uio_oe}, 32'hC7);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single add
    push_cmd(4'd3, 4'd5, 3'b000);
    run();
    check("single_sum", {24'd0, bus.uo_out}, 32'h08);

    // Full FIFO, fifth push dropped
    load_four();
    push_cmd(4'd1, 4'd1, 3'b000);
    run();
    check("full_sum", {24'd0, bus.uo_out}, 32'hF0);

    // Empty start keeps checksum
    run();

    // Strobes during WAIT are ignored
    load_four();
    run_expect();
    @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_busy();
    repeat (2) @(negedge clk);
    sel = 1'b1;
    wr  = 1'b1;
    @(negedge clk);
    wr    = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    run();

    // Randomised command lists, undecoded opcodes included
    for (int it = 0; it < 8; it++) begin
      int n;
      n = $urandom_range(1, DEPTH + 1);
      for (int k = 0; k < n; k++) begin
        push_cmd(4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)));
      end
      run();
    end

    // Async reset during the second WAIT
    for (int k = 0; k < 3; k++) push_cmd(4'($urandom), 4'($urandom), 3'($urandom_range(0, 5)));
    run_expect();
    @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_busy();
    repeat (PER + 1) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_uo", {24'd0, bus.uo_out}, 32'd0);
    check("midrst_uio", {24'd0, bus.uio_out}, 32'd0);
    exp_cmd.delete();
    exp_sum.delete();
    exp_cyc.delete();
    mdl_fifo.delete();
    mdl_sum = 8'h00;
    in_done = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run();
    check("post_rst_sum", {24'd0, bus.uo_out}, 32'd0);
    push_cmd(4'd7, 4'd2, 3'b101);
    run();

    check("leftover_cmd", exp_cmd.size(), 32'd0);
    check("leftover_sum", exp_sum.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
